// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: opcode constants, instruction-type enum
// and the immediate-format helper used by imm_gen.
package decode_pkg;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    IT_R   = 3'd0,
    IT_I   = 3'd1,
    IT_S   = 3'd2,
    IT_B   = 3'd3,
    IT_U   = 3'd4,
    IT_J   = 3'd5,
    IT_ILL = 3'd7
  } itype_e;

  function automatic itype_e classify(input logic [6:0] op);
    itype_e t;
    case (op)
      OP_REG:                    t = IT_R;
      OP_IMM, OP_LOAD, OP_JALR:  t = IT_I;
      OP_STORE:                  t = IT_S;
      OP_BRANCH:                 t = IT_B;
      OP_LUI, OP_AUIPC:          t = IT_U;
      OP_JAL:                    t = IT_J;
      default:                   t = IT_ILL;
    endcase
    return t;
  endfunction

  // Anything not otherwise listed (including ILL) falls back to the I-format.
  function automatic logic [31:0] imm_fmt(input itype_e t, input logic [31:0] inst);
    logic [31:0] imm;
    case (t)
      IT_U: imm = {inst[31:12], 12'b0};
      IT_J: imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      IT_B: imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IT_S: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IT_R: imm = 32'b0;
      default: begin
        if (inst[6:0] == OP_IMM && inst[13:12] == 2'b01)
          imm = {27'b0, inst[24:20]};
        else
          imm = {{20{inst[31]}}, inst[31:20]};
      end
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational field extraction and immediate generation for one instruction.
// DECODE_ILLEGAL_DETECT_EN keeps unsupported opcodes as ILL; otherwise they decode as I-type.
module imm_gen
  import decode_pkg::*;
(
  input  logic [31:0] inst,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [2:0]  funct3,
  output logic        funct7,
  output logic [31:0] imm,
  output logic [2:0]  itype,
  output logic        need_lsb,
  output logic        illegal
);

  itype_e raw_type;
  itype_e dec_type;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[30];

  always_comb begin
    raw_type = classify(inst[6:0]);
`ifdef DECODE_ILLEGAL_DETECT_EN
    dec_type = raw_type;
    illegal  = (raw_type == IT_ILL);
`else
    dec_type = (raw_type == IT_ILL) ? IT_I : raw_type;
    illegal  = 1'b0;
`endif
  end

  assign itype    = dec_type;
  assign imm      = imm_fmt(dec_type, inst);
  assign need_lsb = (inst[6:0] == OP_LOAD) || (inst[6:0] == OP_STORE);

endmodule

// File: rtl/decode_issue_queue.sv
// Instruction buffer with combinational decode of the head and back-pressured issue.
// DECODE_ILLEGAL_DETECT_EN lets ILL heads issue under RoB back-pressure only.
module decode_issue_queue
  import decode_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       flush_in,
  input  logic                       fetch_valid,
  input  logic [31:0]                fetch_inst,
  input  logic [31:0]                fetch_pc,
  output logic                       fetch_ready,
  input  logic                       RS_full,
  input  logic                       LSB_full,
  input  logic                       RoB_full,
  input  logic                       RoB_stall,
  output logic                       issue_valid,
  output logic [6:0]                 opcode,
  output logic [4:0]                 rd,
  output logic [4:0]                 rs1,
  output logic [4:0]                 rs2,
  output logic [2:0]                 funct3,
  output logic                       funct7,
  output logic [31:0]                imm,
  output logic [31:0]                issue_pc,
  output logic                       need_LSB,
  output logic [2:0]                 itype,
  output logic                       illegal,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          full;
  logic          empty;
  logic          stall;
  logic          push;
  logic          pop;
  logic [31:0]   head_inst;
  logic          head_need_lsb;
  logic          head_illegal;

  assign head_inst = inst_mem[head];
  assign issue_pc  = pc_mem[head];

  imm_gen u_imm_gen (
    .inst     (head_inst),
    .opcode   (opcode),
    .rd       (rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .funct3   (funct3),
    .funct7   (funct7),
    .imm      (imm),
    .itype    (itype),
    .need_lsb (head_need_lsb),
    .illegal  (head_illegal)
  );

  always_comb begin
`ifdef DECODE_ILLEGAL_DETECT_EN
    stall = RoB_full || RoB_stall ||
            (!head_illegal && ((head_need_lsb && LSB_full) || (!head_need_lsb && RS_full)));
`else
    stall = RoB_full || RoB_stall || (head_need_lsb && LSB_full) || (!head_need_lsb && RS_full);
`endif
  end

  assign full        = (count == FULL_CNT);
  assign empty       = (count == '0);
  assign need_LSB    = head_need_lsb;
  assign illegal     = head_illegal && !empty;
  assign fetch_ready = !full && rdy_in && !rst_in;
  assign issue_valid = !empty && !stall && rdy_in && !flush_in;
  assign push        = fetch_valid && fetch_ready && !flush_in;
  assign pop         = issue_valid;

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_in) begin
    if (push) begin
      inst_mem[tail] <= fetch_inst;
      pc_mem[tail]   <= fetch_pc;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy_in && flush_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)
        tail <= tail + 1'b1;
      if (pop)
        head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/decode_issue_queue.md
DECODE_ISSUE_QUEUE -- requirements
Module: decode_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, instruction-buffer entries; power of two, 2..16.
REQ-002 SHALL have clk_in  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have rst_in  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have rdy_in  input  1  global ready; low pauses the block.
REQ-005 SHALL have flush_in  input  1  discard all buffered instructions (mispredict).
REQ-006 SHALL have fetch_valid, fetch_inst[31:0], fetch_pc[31:0]  input  1/32/32  fetch push channel.
REQ-007 SHALL have fetch_ready  output  1  buffer can accept a push this cycle.
REQ-008 SHALL have RS_full, LSB_full, RoB_full, RoB_stall  input  1 each  backend back-pressure.
REQ-009 SHALL have issue_valid  output  1  head decoded and consumed this cycle.
REQ-010 SHALL have opcode[6:0], rd[4:0], rs1[4:0], rs2[4:0], funct3[2:0], funct7[0], imm[31:0], issue_pc[31:0], need_LSB, itype[2:0]  output  decoded head fields.
REQ-011 SHALL have illegal  output  1  head opcode not RV32I-supported.
REQ-012 SHALL have count  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-013 Buffer SHALL be a circular FIFO of {inst, pc}; head/tail pointers wrap modulo DEPTH.
REQ-014 Push SHALL occur on the edge where fetch_valid && fetch_ready && rdy_in && !flush_in.
REQ-015 fetch_ready SHALL equal !full && rdy_in; no push when full, even if a pop occurs that cycle.
REQ-016 Decode SHALL be combinational from the head entry; an entry pushed at edge k drives outputs from cycle k+1 (one-cycle latency).
REQ-017 Fields: opcode=inst[6:0], rd=inst[11:7], funct3=inst[14:12], rs1=inst[19:15], rs2=inst[24:20], funct7=inst[30].
REQ-018 itype SHALL be R(0110011), I(0010011/0000011/1100111), S(0100011), B(1100011), U(0110111/0010111), J(1101111), ILL otherwise.
REQ-019 imm SHALL be: U {inst[31:12],12'b0}; J sign-extended 21-bit; B sign-extended 13-bit; S sign-extended 12-bit; shift-imm (0010011 with funct3 001/101) {27'b0,inst[24:20]}; other I sign-extended inst[31:20]; R zero.
REQ-020 need_LSB SHALL be 1 for opcodes 0000011 and 0100011 only.
REQ-021 stall SHALL be RoB_full || RoB_stall || (need_LSB && LSB_full) || (!need_LSB && RS_full).
REQ-022 issue_valid SHALL be !empty && !stall && rdy_in && !flush_in; the backend accepts unconditionally, so issue_valid high pops the head at that edge.
REQ-023 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-024 flush_in SHALL reset head, tail, and count to 0 at the next edge, ignoring that cycle's push and pop.
REQ-025 rdy_in low SHALL freeze all state, with issue_valid=0 and fetch_ready=0.
REQ-026 Empty buffer SHALL drive issue_valid=0; field outputs then are don't-care.

Reset
REQ-027 rst_in SHALL asynchronously clear head, tail, and count to 0, giving issue_valid=0, fetch_ready=0 while asserted and 1 after release, and illegal=0.
REQ-028 Reset mid-operation SHALL discard all entries; buffer contents need not be cleared.

Configuration
REQ-029 Macro DECODE_ILLEGAL_DETECT_EN defined: ILL heads drive illegal=1, need_LSB=0, and issue under RoB back-pressure only (RS_full and LSB_full ignored).
REQ-030 Macro undefined: illegal tied 0; ILL heads decode and issue as I-type.

Structure
REQ-031 Shared package decode_pkg SHALL hold opcode constants, the itype enum, and the immediate-format helper.
REQ-032 Immediate generation plus field extraction SHALL be sub-module imm_gen, purely combinational; FIFO and control stay in decode_issue_queue.

Verification
REQ-033 Push 0x00500093 at pc 0x0 into an empty buffer -> next cycle: issue_valid=1, rd=1, rs1=0, imm=0x5, itype=I, need_LSB=0.
REQ-034 Push 0xFFDFF0EF (jal x1,-4) -> imm=0xFFFFFFFC, itype=J; push 0x4030D093 (srai) -> imm=0x3, funct7=1.
REQ-035 DEPTH=4, RoB_full=1, push 4 entries -> count=4, fetch_ready=0; release RoB_full -> one pop per cycle in push order, pcs preserved.
REQ-036 Head sw 0x00112023 with LSB_full=1, RS_full=0 -> issue_valid=0, count held; head addi with RS_full=1 -> issue_valid=0.
REQ-037 count=3, flush_in=1 with fetch_valid=1 -> next cycle count=0, issue_valid=0, pushed instruction lost.
REQ-038 DECODE_ILLEGAL_DETECT_EN defined, push 0x00000000 with RS_full=1 -> issue_valid=1, illegal=1; macro undefined -> illegal=0, issue_valid=0.
